fetch_unit: RTL

Instruction fetch stage directly upstream of the decoder. Generates sequential word-aligned fetch addresses and issues them to instruction memory over a valid/ready request channel. Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready channel. A redirect from branch resolution flushes buffered words and discards in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_unit_checker.sv | 28 ++
 rtl/fetch_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: buffered entry layout, instruction size
// and the default reset vector.
package fetch_unit_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush that empties it in one cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty_o = (count_q == {CW{1'b0}});
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_o || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1'b1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1'b1);
      else           rd_ptr_d = rd_ptr_q;
      if (do_push_s && !do_pop_s)      count_d = count_q + CW'(1'b1);
      else if (!do_push_s && do_pop_s) count_d = count_q - CW'(1'b1);
      else                             count_d = count_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; an empty FIFO's head is masked by the consumer.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i && !rst_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit_checker.sv
// Invariants on the fetch stage's credit and discard bookkeeping.
module fetch_unit_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          resp_valid_i,
  input logic          push_i,
  input logic          pop_i,
  input logic          fifo_full_i,
  input logic [CW-1:0] outstanding_i,
  input logic [CW-1:0] discard_i
);

  a_resp_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_valid_i |-> (outstanding_i != {CW{1'b0}}));

  a_outstanding_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_i <= CW'(DEPTH));

  a_discard_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    discard_i <= outstanding_i);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (push_i && fifo_full_i) |-> pop_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential requests, response buffering
// with PC tagging, and redirect flush with discard of stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count_s;
  logic [SW-1:0] credits_used_s;
  logic          fifo_empty_s, fifo_full_s;
  logic          req_fire_s, keep_s, pop_s;
  fetch_entry_t  head_s, push_entry_s;

  // Credits count both buffered and in-flight words, so every response has a slot.
  assign credits_used_s = {1'b0, fifo_count_s} + {1'b0, outstanding_q};
  assign imem_req_valid = !rst && (credits_used_s < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  assign out_valid = !rst && !fifo_empty_s;
  assign out_instr = out_valid ? head_s.instr : 32'h0000_0000;
  assign out_pc    = out_valid ? head_s.pc    : 32'h0000_0000;
  assign pop_s     = out_valid && out_ready && !redirect_valid;

  assign push_entry_s = '{pc: resp_pc_q, instr: imem_resp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    keep_s        = 1'b0;
    if (req_fire_s && !imem_resp_valid)      outstanding_d = outstanding_q + CW'(1'b1);
    else if (!req_fire_s && imem_resp_valid) outstanding_d = outstanding_q - CW'(1'b1);
    else                                     outstanding_d = outstanding_q;
    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      discard_d  = outstanding_d;
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
    end else begin
      if (req_fire_s) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      else            fetch_pc_d = fetch_pc_q;
      if (imem_resp_valid && (discard_q != {CW{1'b0}})) begin
        discard_d = discard_q - CW'(1'b1);
      end else if (imem_resp_valid) begin
        keep_s    = 1'b1;
        resp_pc_d = resp_pc_q + 32'(INSTR_BYTES);
      end else begin
        discard_d = discard_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      discard_q     <= {CW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (keep_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (fifo_count_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s)
  );

  fetch_unit_checker #(.DEPTH(DEPTH), .CW(CW)) u_checker (
    .clk_i         (clk),
    .rst_i         (rst),
    .resp_valid_i  (imem_resp_valid),
    .push_i        (keep_s),
    .pop_i         (pop_s),
    .fifo_full_i   (fifo_full_s),
    .outstanding_i (outstanding_q),
    .discard_i     (discard_q)
  );

endmodule
